hand_display_sequencer: RTL and testbench

HAND_DISPLAY_SEQUENCER -- requirements
Module: hand_display_sequencer

---
 rtl/hand_display_sequencer.sv | 107 ++++++++++
 tb/tb_hand_display_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hand_display_sequencer.sv
// hand_display_sequencer: converts hand totals to character codes and sequences
// the status message, flashing it a fixed number of times on entry to a result.
module hand_display_sequencer #(
   parameter int HAND_W      = 5,
   parameter int BLINK_DIV   = 25_000_000,
   parameter int BLINK_REPS  = 3,
   parameter int LZ_SUPPRESS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [HAND_W-1:0] player_hand,
   input  logic [HAND_W-1:0] dealer_hand,
   input  logic [3:0]        game_state,
   input  logic              hide_dealer,
   output logic [11:0]       player_chars,
   output logic [11:0]       dealer_chars,
   output logic [23:0]       msg_chars,
   output logic              disp_upd
);
   localparam logic [3:0] S_RESET       = 4'd0;
   localparam logic [3:0] S_DEAL_DEALER = 4'd3;
   localparam logic [3:0] S_RESULT_WIN  = 4'd6;
   localparam logic [3:0] S_RESULT_LOSE = 4'd7;
   localparam logic [3:0] S_RESULT_TIE  = 4'd8;
   localparam int         PW            = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [5:0] BL            = 6'h3F;

   typedef enum logic [1:0] {STEADY, BLINK_OFF, BLINK_ON} state_t;

   function automatic logic [5:0] ltr(input logic [7:0] c);
      return 6'(c - 8'd55);
   endfunction

   function automatic logic [11:0] conv(input logic [5:0] v);
      logic [5:0] t, u;
      t = v / 6'd10;
      u = v % 6'd10;
      return {(LZ_SUPPRESS != 0 && v < 6'd10) ? BL : t, u};
   endfunction

   state_t        r_st, w_st_nxt;
   logic [3:0]    r_rep;
   logic [PW-1:0] r_pre;
   logic [3:0]    r_prev;
   logic [11:0]   r_p, r_d;
   logic [23:0]   r_m;
   logic          r_upd;
   logic          w_chg, w_res, w_tick;
   logic [23:0]   w_base, w_msg;
   logic [11:0]   w_pc, w_dc;

   assign w_chg  = game_state != r_prev;
   assign w_res  = game_state inside {S_RESULT_WIN, S_RESULT_LOSE, S_RESULT_TIE};
   assign w_tick = r_pre == PW'(BLINK_DIV - 1);
   assign w_base = (game_state == S_RESET)       ? {ltr("S"), ltr("T"), ltr("R"), ltr("T")} :
                   (game_state == S_DEAL_DEALER) ? {ltr("D"), ltr("E"), ltr("A"), ltr("L")} :
                   (game_state == S_RESULT_WIN)  ? {BL, ltr("W"), ltr("I"), ltr("N")} :
                   (game_state == S_RESULT_LOSE) ? {ltr("L"), ltr("O"), ltr("S"), ltr("E")} :
                   (game_state == S_RESULT_TIE)  ? {BL, ltr("T"), ltr("I"), ltr("E")} :
                                                   {ltr("P"), ltr("L"), ltr("A"), ltr("Y")};
   assign w_pc   = conv(6'(player_hand));
   assign w_dc   = hide_dealer ? 12'hFFF : conv(6'(dealer_hand));

   // A game_state change always overrides a coincident tick.
   always_comb begin
      w_st_nxt = r_st;
      if (w_chg) begin
         if (w_res) w_st_nxt = BLINK_OFF;
         else w_st_nxt = STEADY;
      end else if (w_tick) begin
         if (r_st == BLINK_OFF) w_st_nxt = BLINK_ON;
         else if (r_st == BLINK_ON && r_rep != 4'd0) w_st_nxt = BLINK_OFF;
         else w_st_nxt = STEADY;
      end
   end

   // The message follows the state being entered so blanking starts on the change edge.
   assign w_msg = (w_st_nxt == BLINK_OFF) ? {4{BL}} : w_base;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_st   <= STEADY;
         r_rep  <= 4'd0;
         r_pre  <= '0;
         r_prev <= 4'd0;
         r_p    <= 12'hFFF;
         r_d    <= 12'hFFF;
         r_m    <= 24'hFFFFFF;
         r_upd  <= 1'b0;
      end else begin
         r_st   <= w_st_nxt;
         r_pre  <= ((w_chg && w_res) || w_tick) ? '0 : r_pre + PW'(1);
         r_rep  <= (w_chg && w_res) ? 4'(BLINK_REPS) :
                   (!w_chg && w_tick && r_st == BLINK_OFF) ? r_rep - 4'd1 : r_rep;
         r_prev <= game_state;
         r_p    <= w_pc;
         r_d    <= w_dc;
         r_m    <= w_msg;
         r_upd  <= {w_pc, w_dc, w_msg} != {r_p, r_d, r_m};
      end
   end

   assign player_chars = r_p;
   assign dealer_chars = r_d;
   assign msg_chars    = r_m;
   assign disp_upd     = r_upd;
endmodule

// File: tb/tb_hand_display_sequencer.sv
// tb_hand_display_sequencer: scoreboard bench driving an independent cycle model
// of the display sequencer alongside directed literal checks.
module tb_hand_display_sequencer;
   localparam int DIV  = 4;
   localparam int REPS = 2;
   localparam logic [3:0] S_RESET = 4'd0, S_DEAL_DEALER = 4'd3, S_PLAYER_TURN = 4'd4;
   localparam logic [3:0] S_WIN = 4'd6, S_LOSE = 4'd7, S_TIE = 4'd8;
   localparam logic [23:0] BLANK = 24'hFFFFFF;
   localparam logic [23:0] STRT  = {6'h1C, 6'h1D, 6'h1B, 6'h1D};
   localparam logic [23:0] DEAL  = {6'h0D, 6'h0E, 6'h0A, 6'h15};
   localparam logic [23:0] WIN   = {6'h3F, 6'h20, 6'h12, 6'h17};
   localparam logic [23:0] LOSE  = {6'h15, 6'h18, 6'h1C, 6'h0E};
   localparam logic [23:0] TIE   = {6'h3F, 6'h1D, 6'h12, 6'h0E};
   localparam logic [23:0] PLAY  = {6'h19, 6'h15, 6'h0A, 6'h22};

   logic        clk = 1'b0, rst_n = 1'b0, hide = 1'b0;
   logic [5:0]  ph = 6'd0, dh = 6'd0;
   logic [3:0]  gs = 4'd0;
   logic [11:0] player_chars, dealer_chars;
   logic [23:0] msg_chars;
   logic        disp_upd;

   hand_display_sequencer #(.HAND_W(6), .BLINK_DIV(DIV), .BLINK_REPS(REPS), .LZ_SUPPRESS(1)) dut (
      .clk(clk), .rst_n(rst_n), .player_hand(ph), .dealer_hand(dh), .game_state(gs),
      .hide_dealer(hide), .player_chars(player_chars), .dealer_chars(dealer_chars),
      .msg_chars(msg_chars), .disp_upd(disp_upd)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [11:0] p;
      logic [11:0] d;
      logic [23:0] m;
      logic        u;
   } exp_t;

   exp_t        q[$];
   int          checks = 0, failures = 0;
   int          m_st = 0, m_rep = 0, m_pre = 0;
   logic [3:0]  m_prev = 4'd0;
   logic [47:0] m_last = '1;

   task automatic check(input string tag, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [11:0] conv(input logic [5:0] v);
      int t, u;
      t = 0;
      u = int'(v);
      while (u >= 10) begin
         u -= 10;
         t++;
      end
      return {(v < 6'd10) ? 6'h3F : 6'(t), 6'(u)};
   endfunction

   function automatic logic [23:0] base(input logic [3:0] g);
      case (g)
         S_RESET:       return STRT;
         S_DEAL_DEALER: return DEAL;
         S_WIN:         return WIN;
         S_LOSE:        return LOSE;
         S_TIE:         return TIE;
         default:       return PLAY;
      endcase
   endfunction

   // m_st: 0 steady, 1 blank phase, 2 lit phase
   task automatic step();
      exp_t e;
      logic tick, chg, res;
      if (!rst_n) begin
         m_st = 0; m_rep = 0; m_pre = 0; m_prev = 4'd0; m_last = '1;
         e.p = 12'hFFF; e.d = 12'hFFF; e.m = BLANK; e.u = 1'b0;
      end else begin
         tick = (m_pre == DIV - 1);
         chg  = (gs != m_prev);
         res  = (gs == S_WIN) || (gs == S_LOSE) || (gs == S_TIE);
         m_pre = tick ? 0 : m_pre + 1;
         if (chg) begin
            if (res) begin m_st = 1; m_rep = REPS; m_pre = 0; end
            else m_st = 0;
         end else if (tick) begin
            if (m_st == 1) begin m_st = 2; m_rep--; end
            else if (m_st == 2) m_st = (m_rep != 0) ? 1 : 0;
         end
         m_prev = gs;
         e.p = conv(ph);
         e.d = hide ? 12'hFFF : conv(dh);
         e.m = (m_st == 1) ? BLANK : base(gs);
         e.u = ({e.p, e.d, e.m} != m_last);
         m_last = {e.p, e.d, e.m};
      end
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      check("player", 24'(player_chars), 24'(e.p));
      check("dealer", 24'(dealer_chars), 24'(e.d));
      check("msg", msg_chars, e.m);
      check("upd", 24'(disp_upd), 24'(e.u));
   endtask

   initial begin
      int blanks, ups;
      repeat (2) step();
      check("rst_msg", msg_chars, BLANK);
      check("rst_player", 24'(player_chars), 24'hFFF);

      rst_n = 1'b1; gs = S_RESET; ph = 6'd7; dh = 6'd17; hide = 1'b1;
      step();
      check("strt", msg_chars, STRT);
      check("p7", 24'(player_chars), 24'hFC7);
      check("hidden", 24'(dealer_chars), 24'hFFF);
      step();
      ph = 6'd21; step(); check("p21", 24'(player_chars), 24'h081);
      ph = 6'd31; step(); check("p31", 24'(player_chars), 24'h0C1);
      ph = 6'd63; step(); check("p63", 24'(player_chars), 24'h183);
      ph = 6'd9;  step(); check("p9", 24'(player_chars), 24'hFC9);
      ph = 6'd10; step(); check("p10", 24'(player_chars), 24'h040);
      hide = 1'b0; step();
      check("d17", 24'(dealer_chars), 24'h047);
      check("d17_upd", 24'(disp_upd), 24'd1);
      step();
      check("d17_quiet", 24'(disp_upd), 24'd0);

      gs = S_DEAL_DEALER; step(); check("deal", msg_chars, DEAL);
      gs = S_PLAYER_TURN; step(); check("play", msg_chars, PLAY);
      ups = 0;
      repeat (10) begin step(); if (disp_upd) ups++; end
      check("steady_upd", 24'(ups), 24'd0);

      gs = S_LOSE; blanks = 0; ups = 0;
      repeat (20) begin
         step();
         if (msg_chars == BLANK) blanks++;
         if (disp_upd) ups++;
      end
      check("lose_blanks", 24'(blanks), 24'd8);
      check("lose_pulses", 24'(ups), 24'd4);
      check("lose_final", msg_chars, LOSE);

      gs = S_WIN; repeat (6) step();
      gs = S_RESET; step(); check("abort_strt", msg_chars, STRT);
      repeat (10) step();
      check("abort_steady", msg_chars, STRT);

      gs = S_WIN; repeat (6) step();
      gs = S_TIE; step(); check("tie_restart", msg_chars, BLANK);
      repeat (3) step();
      gs = S_LOSE; step(); check("tick_chg", msg_chars, BLANK);
      repeat (3) step(); check("tick_chg_hold", msg_chars, BLANK);
      step(); check("tick_chg_on", msg_chars, LOSE);
      repeat (4) step(); check("second_off", msg_chars, BLANK);

      rst_n = 1'b0; gs = S_RESET; step();
      check("midrst_msg", msg_chars, BLANK);
      check("midrst_dealer", 24'(dealer_chars), 24'hFFF);
      rst_n = 1'b1; step(); check("post_rst", msg_chars, STRT);
      repeat (12) step();
      check("post_rst_steady", msg_chars, STRT);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
